// File: rtl/booth_pkg.sv
// Shared types and the radix-4 Booth digit decode used by the sequential
// encoder and any future parallel encoders.
package booth_pkg;

  typedef struct packed {
    logic single;
    logic double;
    logic negative;
  } booth_digit_t;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } booth_state_t;

  // bits = {x[2i+1], x[2i], x[2i-1]}; the digit is x[2i-1] + x[2i] - 2*x[2i+1].
  function automatic booth_digit_t booth_encode(input logic [2:0] bits);
    booth_digit_t d;
    d.single   = bits[1] ^ bits[0];
    d.double   = (bits == 3'b011) || (bits == 3'b100);
    d.negative = bits[2];
    return d;
  endfunction

endpackage

// File: rtl/booth_encoder_cell.sv
// Combinational 3-bit window to Single/Double/Negative decode.
module booth_encoder_cell
  import booth_pkg::*;
(
  input  logic [2:0]   bits_i,
  output booth_digit_t digit_o
);

  assign digit_o = booth_encode(bits_i);

endmodule

// File: rtl/booth_digit_encoder.sv
// Sequential radix-4 Booth encoder: takes one N-bit multiplier, streams N/2
// digits LSB-first over a valid/ready interface.
module booth_digit_encoder
  import booth_pkg::*;
#(
  parameter  int N  = 32,
  localparam int D  = N / 2,
  localparam int IW = (D > 1) ? $clog2(D) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_x,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_single,
  output logic          out_double,
  output logic          out_negative,
  output logic [IW-1:0] out_index,
  output logic          out_last
);

  if ((N < 4) || (N % 2 != 0)) begin : g_bad_n
    $error("booth_digit_encoder: N must be even and >= 4");
  end

  booth_state_t  state_q, state_d;
  logic [N:0]    sr_q, sr_d;
  logic [IW-1:0] idx_q, idx_d;
  booth_digit_t  cell_digit;
  logic          scan, last;

  booth_encoder_cell u_cell (
    .bits_i  (sr_q[2:0]),
    .digit_o (cell_digit)
  );

  assign scan = (state_q == SCAN);
  assign last = scan && (idx_q == IW'(D - 1));

  // out_ready -> in_ready is combinational so the next operand loads on the
  // final digit handshake without a bubble.
  assign in_ready     = !scan || (last && out_ready);
  assign out_valid    = scan;
  assign out_single   = scan && cell_digit.single;
  assign out_double   = scan && cell_digit.double;
  assign out_negative = scan && cell_digit.negative;
  assign out_index    = idx_q;
  assign out_last     = last;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sr_d    = {in_x, 1'b0};
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (out_ready) begin
          if (!last) begin
            sr_d  = sr_q >> 2;
            idx_d = idx_q + 1'b1;
          end else if (in_valid) begin
            sr_d  = {in_x, 1'b0};
            idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_booth_digit_encoder.sv
// Scoreboard bench for booth_digit_encoder: expected digits come from the
// arithmetic digit definition, and every operand is rebuilt from its digits.
module tb_booth_digit_encoder;

  localparam int N  = 32;
  localparam int D  = N / 2;
  localparam int IW = $clog2(D);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  in_x = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_single, out_double, out_negative, out_last;
  logic [IW-1:0] out_index;

  booth_digit_encoder #(.N(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_x         (in_x),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_single   (out_single),
    .out_double   (out_double),
    .out_negative (out_negative),
    .out_index    (out_index),
    .out_last     (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit s;
    bit d;
    bit n;
    int idx;
    bit last;
    bit b2b;
  } exp_t;

  exp_t        exp_q[$];
  logic [N-1:0] op_q[$];
  int          tests = 0;
  int          fails = 0;
  int          rdy_mode = 0;  // 0: ready high, 1: random, 2: driven by main
  longint      acc = 0;

  task automatic chk(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Digit i value = x[2i-1] + x[2i] - 2*x[2i+1], with x[-1] = 0.
  task automatic push_operand(input logic [N-1:0] x, input bit b2b);
    for (int i = 0; i < D; i++) begin
      int lo, mid, hi, v;
      exp_t e;
      lo  = (i == 0) ? 0 : int'(x[2*i-1]);
      mid = int'(x[2*i]);
      hi  = int'(x[2*i+1]);
      v   = lo + mid - 2 * hi;
      e.s    = (v == 1) || (v == -1);
      e.d    = (v == 2) || (v == -2);
      e.n    = (hi == 1);
      e.idx  = i;
      e.last = (i == D - 1);
      e.b2b  = b2b && (i == 0);
      exp_q.push_back(e);
    end
    op_q.push_back(x);
  endtask

  task automatic send(input logic [N-1:0] x, input bit keep);
    bit ok;
    ok = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_x     = x;
    for (int c = 0; c < 300; c++) begin
      #1;
      if (in_ready) begin
        if (out_valid) chk("accept_in_scan_only_on_last", out_last, 1);
        push_operand(x, out_valid);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk);
    if (!keep) #1 in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
    else if (rdy_mode == 0) out_ready = 1'b1;
  end

  // Monitor: samples late in the low phase, after all drivers have settled.
  bit            hold_pend = 0, last_hs = 0;
  logic [IW+3:0] held;
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      hold_pend = 0;
      last_hs   = 0;
    end else begin
      if (hold_pend)
        chk("hold_stable", {out_valid, out_single, out_double, out_negative, out_index}, held);
      if (last_hs && exp_q.size() > 0 && exp_q[0].b2b)
        chk("no_bubble", out_valid, 1);
      hold_pend = 0;
      last_hs   = 0;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_digit", out_index, -1);
        end else begin
          exp_t e;
          e = exp_q[0];
          chk("digit_sdn", {out_single, out_double, out_negative}, {e.s, e.d, e.n});
          chk("digit_index", out_index, e.idx);
          chk("digit_last", out_last, e.last);
          if (out_ready) begin
            longint v;
            void'(exp_q.pop_front());
            v = out_single ? 1 : (out_double ? 2 : 0);
            if (out_negative) v = -v;
            acc += v * (longint'(1) << (2 * int'(out_index)));
            if (e.last) begin
              logic [N-1:0] x;
              x = op_q.pop_front();
              chk("reconstructed_sum", acc, longint'($signed(x)));
              acc     = 0;
              last_hs = 1;
            end
          end else begin
            hold_pend = 1;
            held = {out_valid, out_single, out_double, out_negative, out_index};
          end
        end
      end
    end
  end

  task automatic wait_index(input int idx);
    bit ok;
    ok = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      #1;
      if (out_valid && out_index == IW'(idx)) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("wait_index_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int c = 0; c < 3000 && exp_q.size() > 0; c++) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin
    #2;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_outs", {out_valid, out_single, out_double, out_negative, out_index, out_last}, 0);
    #20 rst_n = 1'b1;

    // Simple operands with ready held high.
    send(32'd10, 0);
    drain();
    @(negedge clk); #1;
    chk("idle_in_ready", in_ready, 1);
    chk("idle_out_valid", out_valid, 0);
    send(32'hFFFF_FFFF, 0);
    send(32'h8000_0000, 0);
    drain();

    // Backpressure at index 5.
    send(32'h1234_5678, 0);
    wait_index(4);
    rdy_mode = 2;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      out_ready = 1'b0;
      #1 chk("stall_index", out_index, 5);
    end
    @(negedge clk);
    out_ready = 1'b1;
    rdy_mode  = 0;
    drain();

    // Back-to-back: second operand loads on the final handshake.
    send(32'd10, 1);
    send(-32'sd7, 0);
    drain();

    // Reset mid-operand.
    send(32'hDEAD_BEEF, 0);
    wait_index(7);
    rst_n = 1'b0;
    #1;
    chk("midreset_outs", {out_valid, out_single, out_double, out_negative, out_index, out_last}, 0);
    chk("midreset_in_ready", in_ready, 1);
    exp_q.delete();
    op_q.delete();
    acc = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send(32'd3, 0);
    drain();

    // Random operands with random backpressure and gaps.
    rdy_mode = 1;
    for (int t = 0; t < 24; t++) begin
      logic [N-1:0] x;
      x = $urandom();
      if (t % 6 == 0) x = '0;
      send(x, (t != 23) && ($urandom_range(0, 1) == 1));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(negedge clk);
    end
    drain();
    rdy_mode = 0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
